// File: rtl/banked_operational_memory.sv
// Dual-port user/kernel banked store: port A fetch, port B load/store, with a sticky kernel range fault.
// Optional same-cycle port B -> port A write forwarding is built when MEM_FWD_EN is defined.
module banked_operational_memory #(
  parameter int ADDR_W      = 16,
  parameter int KERN_ADDR_W = 15,
  parameter int DATA_W      = 32,
  parameter int READ_LAT    = 1,
  parameter     KERN_INIT   = "RAM.mif"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              operationMode,
  input  logic [ADDR_W-1:0] fetchAddress,
  input  logic              fetchEnable,
  output logic [DATA_W-1:0] fetchOutput,
  output logic              fetchValid,
  input  logic [ADDR_W-1:0] memAccessAddress,
  input  logic              memAccessWren,
  input  logic [DATA_W-1:0] memAccessData,
  input  logic              memAccessRden,
  output logic [DATA_W-1:0] memAccessOutput,
  output logic              memAccessValid,
  output logic              accessFault,
  output logic [ADDR_W-1:0] faultAddress,
  input  logic              faultClear
);

  localparam int USER_DEPTH = 1 << ADDR_W;
  localparam int KERN_DEPTH = 1 << KERN_ADDR_W;

  logic [DATA_W-1:0] userMem [USER_DEPTH];
  (* ram_init_file = KERN_INIT *) logic [DATA_W-1:0] kernMem [KERN_DEPTH];

  logic outOfRangeA, outOfRangeB;
  logic faultA, faultB, writeCommit;

  // Kernel addresses above the kernel bank depth are illegal; user mode never faults.
  assign outOfRangeA = operationMode && ((fetchAddress >> KERN_ADDR_W) != '0);
  assign outOfRangeB = operationMode && ((memAccessAddress >> KERN_ADDR_W) != '0);
  assign faultA      = fetchEnable && outOfRangeA;
  assign faultB      = (memAccessWren || memAccessRden) && outOfRangeB;
  assign writeCommit = memAccessWren && !rst && !outOfRangeB;

  always_ff @(posedge clk) begin
    if (writeCommit && !operationMode) userMem[memAccessAddress] <= memAccessData;
    if (writeCommit && operationMode) kernMem[memAccessAddress[KERN_ADDR_W-1:0]] <= memAccessData;
  end

  // Raw RAM read registers; they only load on a request so data holds between reads.
  logic [DATA_W-1:0] userRdA, kernRdA, userRdB, kernRdB;

  always_ff @(posedge clk) begin
    if (fetchEnable) begin
      userRdA <= userMem[fetchAddress];
      kernRdA <= kernMem[fetchAddress[KERN_ADDR_W-1:0]];
    end
    if (memAccessRden) begin
      userRdB <= userMem[memAccessAddress];
      kernRdB <= kernMem[memAccessAddress[KERN_ADDR_W-1:0]];
    end
  end

  // Bank tag and zero flag travel with each request; zero after reset keeps outputs at 0.
  logic validA, modeA, zeroA, validB, modeB, zeroB;

  always_ff @(posedge clk) begin
    if (rst) begin
      validA <= 1'b0;
      modeA  <= 1'b0;
      zeroA  <= 1'b1;
      validB <= 1'b0;
      modeB  <= 1'b0;
      zeroB  <= 1'b1;
    end else begin
      validA <= fetchEnable;
      validB <= memAccessRden;
      if (fetchEnable) begin
        modeA <= operationMode;
        zeroA <= outOfRangeA;
      end
      if (memAccessRden) begin
        modeB <= operationMode;
        zeroB <= outOfRangeB;
      end
    end
  end

  logic [DATA_W-1:0] rawA, dataA, dataB;

`ifdef MEM_FWD_EN
  logic              fwdHitA;
  logic [DATA_W-1:0] fwdDataA;

  // Both ports share operationMode, so equal addresses imply the same bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwdHitA <= 1'b0;
    end else if (fetchEnable) begin
      fwdHitA  <= writeCommit && (memAccessAddress == fetchAddress);
      fwdDataA <= memAccessData;
    end
  end

  assign rawA = fwdHitA ? fwdDataA : (modeA ? kernRdA : userRdA);
`else
  assign rawA = modeA ? kernRdA : userRdA;
`endif

  assign dataA = zeroA ? '0 : rawA;
  assign dataB = zeroB ? '0 : (modeB ? kernRdB : userRdB);

  generate
    if (READ_LAT == 2) begin : gLat2
      always_ff @(posedge clk) begin
        if (rst) begin
          fetchValid      <= 1'b0;
          fetchOutput     <= '0;
          memAccessValid  <= 1'b0;
          memAccessOutput <= '0;
        end else begin
          fetchValid     <= validA;
          memAccessValid <= validB;
          if (validA) fetchOutput <= dataA;
          if (validB) memAccessOutput <= dataB;
        end
      end
    end else begin : gLat1
      assign fetchValid      = validA;
      assign fetchOutput     = dataA;
      assign memAccessValid  = validB;
      assign memAccessOutput = dataB;
    end
  endgenerate

  // A new fault beats a same-cycle clear; port B's address wins a dual fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      accessFault  <= 1'b0;
      faultAddress <= '0;
    end else if (faultA || faultB) begin
      accessFault <= 1'b1;
      if (!accessFault || faultClear) faultAddress <= faultB ? memAccessAddress : fetchAddress;
    end else if (faultClear) begin
      accessFault  <= 1'b0;
      faultAddress <= '0;
    end
  end

endmodule

// File: tb/tb_banked_operational_memory.sv
// Directed self-checking bench for banked_operational_memory, built with READ_LAT=2.
module tb_banked_operational_memory;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          operationMode;
  logic [AW-1:0] fetchAddress;
  logic          fetchEnable;
  logic [DW-1:0] fetchOutput;
  logic          fetchValid;
  logic [AW-1:0] memAccessAddress;
  logic          memAccessWren;
  logic [DW-1:0] memAccessData;
  logic          memAccessRden;
  logic [DW-1:0] memAccessOutput;
  logic          memAccessValid;
  logic          accessFault;
  logic [AW-1:0] faultAddress;
  logic          faultClear;

  int compared = 0;
  int mismatched = 0;

  banked_operational_memory #(
    .ADDR_W(AW), .KERN_ADDR_W(15), .DATA_W(DW), .READ_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .operationMode(operationMode),
    .fetchAddress(fetchAddress), .fetchEnable(fetchEnable),
    .fetchOutput(fetchOutput), .fetchValid(fetchValid),
    .memAccessAddress(memAccessAddress), .memAccessWren(memAccessWren),
    .memAccessData(memAccessData), .memAccessRden(memAccessRden),
    .memAccessOutput(memAccessOutput), .memAccessValid(memAccessValid),
    .accessFault(accessFault), .faultAddress(faultAddress), .faultClear(faultClear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    operationMode = m; memAccessAddress = a; memAccessData = d; memAccessWren = 1'b1;
    tick();
    memAccessWren = 1'b0;
  endtask

  // Issues a port B read and waits until it completes (two edges).
  task automatic doReadB(input logic m, input logic [AW-1:0] a);
    operationMode = m; memAccessAddress = a; memAccessRden = 1'b1;
    tick();
    memAccessRden = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    compared++;
    if (fetchValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fetchValid: got %b expected 0", fetchValid); end
    compared++;
    if (memAccessValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_memValid: got %b expected 0", memAccessValid); end
    compared++;
    if (accessFault !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fault: got %b expected 0", accessFault); end
    compared++;
    if (fetchOutput !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_fetchOutput: got %h expected 0", fetchOutput); end
    compared++;
    if (memAccessOutput !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_memOutput: got %h expected 0", memAccessOutput); end
    compared++;
    if (faultAddress !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_faultAddress: got %h expected 0", faultAddress); end
  endtask

  task automatic test_write_fetch();
    doWrite(1'b1, 16'h1234, 32'h11112222);
    doWrite(1'b0, 16'h1234, 32'hDEADBEEF);
    operationMode = 1'b0; fetchAddress = 16'h1234; fetchEnable = 1'b1;
    tick();
    fetchEnable = 1'b0;
    compared++;
    if (fetchValid !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_early_valid: got %b expected 0", fetchValid); end
    tick();
    compared++;
    if (fetchValid !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_valid: got %b expected 1", fetchValid); end
    compared++;
    if (fetchOutput !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL fetch_user_data: got %h expected deadbeef", fetchOutput); end
    tick();
    compared++;
    if (fetchValid !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_idle_valid: got %b expected 0", fetchValid); end
    compared++;
    if (fetchOutput !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL fetch_hold_data: got %h expected deadbeef", fetchOutput); end
    doReadB(1'b1, 16'h1234);
    compared++;
    if (memAccessValid !== 1'b1) begin mismatched++; $display("[TB] FAIL kern_read_valid: got %b expected 1", memAccessValid); end
    compared++;
    if (memAccessOutput !== 32'h11112222) begin mismatched++; $display("[TB] FAIL kern_untouched: got %h expected 11112222", memAccessOutput); end
  endtask

  task automatic test_tag_hold();
    doWrite(1'b1, 16'h0010, 32'hCAFE0010);
    doWrite(1'b0, 16'h0010, 32'h00000BAD);
    operationMode = 1'b1; fetchAddress = 16'h0010; fetchEnable = 1'b1;
    tick();
    operationMode = 1'b0; fetchEnable = 1'b0;
    tick();
    compared++;
    if (fetchOutput !== 32'hCAFE0010) begin mismatched++; $display("[TB] FAIL tag_hold_data: got %h expected cafe0010", fetchOutput); end
  endtask

  task automatic test_fault();
    doWrite(1'b1, 16'h0004, 32'h00004444);
    doWrite(1'b1, 16'h8004, 32'h00000055);
    compared++;
    if (accessFault !== 1'b1) begin mismatched++; $display("[TB] FAIL fault_set: got %b expected 1", accessFault); end
    compared++;
    if (faultAddress !== 16'h8004) begin mismatched++; $display("[TB] FAIL fault_addr: got %h expected 8004", faultAddress); end
    operationMode = 1'b1; fetchAddress = 16'h9000; fetchEnable = 1'b1;
    tick();
    fetchEnable = 1'b0;
    compared++;
    if (faultAddress !== 16'h8004) begin mismatched++; $display("[TB] FAIL fault_first_kept: got %h expected 8004", faultAddress); end
    tick();
    compared++;
    if (fetchValid !== 1'b1 || fetchOutput !== 32'h0) begin
      mismatched++; $display("[TB] FAIL fault_fetch_zero: got valid %b data %h expected valid 1 data 0", fetchValid, fetchOutput);
    end
    faultClear = 1'b1;
    tick();
    faultClear = 1'b0;
    compared++;
    if (accessFault !== 1'b0 || faultAddress !== 16'h0) begin
      mismatched++; $display("[TB] FAIL fault_clear: got %b/%h expected 0/0000", accessFault, faultAddress);
    end
    doReadB(1'b1, 16'h0004);
    compared++;
    if (memAccessOutput !== 32'h00004444) begin mismatched++; $display("[TB] FAIL fault_write_suppressed: got %h expected 00004444", memAccessOutput); end
  endtask

  task automatic test_clear_collision();
    operationMode = 1'b1; fetchAddress = 16'hA000; fetchEnable = 1'b1;
    tick();
    fetchEnable = 1'b0;
    faultClear = 1'b1; memAccessAddress = 16'hC000; memAccessRden = 1'b1;
    tick();
    faultClear = 1'b0; memAccessRden = 1'b0;
    compared++;
    if (accessFault !== 1'b1 || faultAddress !== 16'hC000) begin
      mismatched++; $display("[TB] FAIL clear_vs_fault: got %b/%h expected 1/c000", accessFault, faultAddress);
    end
    tick();
    compared++;
    if (memAccessValid !== 1'b1 || memAccessOutput !== 32'h0) begin
      mismatched++; $display("[TB] FAIL oor_read_zero: got valid %b data %h expected valid 1 data 0", memAccessValid, memAccessOutput);
    end
    faultClear = 1'b1;
    tick();
    faultClear = 1'b0;
  endtask

  task automatic test_dual_fault();
    operationMode = 1'b1; fetchAddress = 16'hF000; fetchEnable = 1'b1;
    memAccessAddress = 16'hE000; memAccessRden = 1'b1;
    tick();
    fetchEnable = 1'b0; memAccessRden = 1'b0;
    compared++;
    if (faultAddress !== 16'hE000) begin mismatched++; $display("[TB] FAIL dual_fault_portB: got %h expected e000", faultAddress); end
    faultClear = 1'b1;
    tick();
    faultClear = 1'b0;
  endtask

  task automatic test_user_range();
    doWrite(1'b0, 16'hFFF0, 32'h00000F0F);
    doReadB(1'b0, 16'hFFF0);
    compared++;
    if (memAccessOutput !== 32'h00000F0F || accessFault !== 1'b0) begin
      mismatched++; $display("[TB] FAIL user_high_addr: got %h fault %b expected 00000f0f fault 0", memAccessOutput, accessFault);
    end
  endtask

  task automatic test_read_during_write();
    doWrite(1'b0, 16'h0040, 32'h0000AAAA);
    operationMode = 1'b0; memAccessAddress = 16'h0040; memAccessData = 32'h0000BBBB;
    memAccessWren = 1'b1; memAccessRden = 1'b1;
    tick();
    memAccessWren = 1'b0; memAccessRden = 1'b0;
    tick();
    compared++;
    if (memAccessOutput !== 32'h0000AAAA) begin mismatched++; $display("[TB] FAIL rdw_old_data: got %h expected 0000aaaa", memAccessOutput); end
    doReadB(1'b0, 16'h0040);
    compared++;
    if (memAccessOutput !== 32'h0000BBBB) begin mismatched++; $display("[TB] FAIL rdw_committed: got %h expected 0000bbbb", memAccessOutput); end
  endtask

  task automatic test_forward();
    logic [DW-1:0] expected;
`ifdef MEM_FWD_EN
    expected = 32'h2;
`else
    expected = 32'h1;
`endif
    doWrite(1'b0, 16'h0020, 32'h1);
    operationMode = 1'b0; memAccessAddress = 16'h0020; memAccessData = 32'h2; memAccessWren = 1'b1;
    fetchAddress = 16'h0020; fetchEnable = 1'b1;
    tick();
    memAccessWren = 1'b0; fetchEnable = 1'b0;
    tick();
    compared++;
    if (fetchOutput !== expected) begin mismatched++; $display("[TB] FAIL fetch_vs_write: got %h expected %h", fetchOutput, expected); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [3];
    vals[0] = 32'h0A0A0100; vals[1] = 32'h0B0B0101; vals[2] = 32'h0C0C0102;
    for (int i = 0; i < 3; i++) doWrite(1'b0, 16'h0100 + 16'(i), vals[i]);
    operationMode = 1'b0; fetchEnable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetchAddress = 16'h0100 + 16'(i);
      if (i == 3) fetchEnable = 1'b0;
      tick();
      if (i > 0) begin
        compared++;
        if (fetchValid !== 1'b1 || fetchOutput !== vals[i-1]) begin
          mismatched++; $display("[TB] FAIL b2b_%0d: got valid %b data %h expected valid 1 data %h", i-1, fetchValid, fetchOutput, vals[i-1]);
        end
      end
    end
    tick();
    compared++;
    if (fetchValid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_drain: got %b expected 0", fetchValid); end
  endtask

  task automatic test_reset_inflight();
    doWrite(1'b0, 16'h0300, 32'h66);
    operationMode = 1'b0; fetchEnable = 1'b1; memAccessRden = 1'b1;
    fetchAddress = 16'h0100; memAccessAddress = 16'h0101;
    tick();
    fetchAddress = 16'h0101;
    tick();
    fetchAddress = 16'h0102; rst = 1'b1;
    memAccessRden = 1'b0; memAccessWren = 1'b1; memAccessAddress = 16'h0300; memAccessData = 32'h77;
    tick();
    rst = 1'b0; fetchEnable = 1'b0; memAccessWren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (fetchValid !== 1'b0 || memAccessValid !== 1'b0) begin
        mismatched++; $display("[TB] FAIL rst_drop_%0d: got valids %b/%b expected 0/0", i, fetchValid, memAccessValid);
      end
      tick();
    end
    compared++;
    if (fetchOutput !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_clears_data: got %h expected 0", fetchOutput); end
    doReadB(1'b0, 16'h0300);
    compared++;
    if (memAccessOutput !== 32'h66) begin mismatched++; $display("[TB] FAIL rst_write_blocked: got %h expected 00000066", memAccessOutput); end
  endtask

  initial begin
    rst = 1'b1; operationMode = 1'b0; fetchAddress = '0; fetchEnable = 1'b0;
    memAccessAddress = '0; memAccessWren = 1'b0; memAccessData = '0;
    memAccessRden = 1'b0; faultClear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_write_fetch();
    test_tag_hold();
    test_fault();
    test_clear_collision();
    test_dual_fault();
    test_user_range();
    test_read_during_write();
    test_forward();
    test_back_to_back();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
